// File: rtl/gomoku_pkg.sv
// Shared board constants, cell/direction encodings and scanner state type
// for the Gomoku win scanner.
package gomoku_pkg;

  localparam int BOARD_DIM = 6;
  localparam int N_CELLS   = BOARD_DIM * BOARD_DIM;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    P1    = 2'd1,
    P2    = 2'd2
  } cell_t;

  typedef enum logic [1:0] {
    H = 2'd0,
    V = 2'd1,
    D = 2'd2,
    A = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ADV,
    PROBE,
    CHECK,
    DRAWSCAN,
    DONE
  } win_state_t;

  // Unit step of each line direction on its + side; the - side negates it.
  function automatic logic signed [1:0] dir_drow(dir_t d);
    logic signed [1:0] r;
    r = (d == H) ? 2'sd0 : 2'sd1;
    return r;
  endfunction

  function automatic logic signed [1:0] dir_dcol(dir_t d);
    logic signed [1:0] r;
    case (d)
      H:       r = 2'sd1;
      V:       r = 2'sd0;
      D:       r = 2'sd1;
      default: r = -2'sd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/win_scanner_pos_to_rc.sv
// Splits a linear board index into (row, col) with a compare chain
// against row start offsets, avoiding a divider.
module pos_to_rc #(
  parameter int BOARD_DIM = 6
) (
  input  logic [5:0] pos,
  output logic [2:0] row,
  output logic [2:0] col
);

  always_comb begin
    row = '0;
    col = pos[2:0];
    for (int r = 1; r < BOARD_DIM; r++) begin
      if (pos >= 6'(r * BOARD_DIM)) begin
        row = 3'(r);
        col = 3'(pos - 6'(r * BOARD_DIM));
      end
    end
  end

endmodule

// File: rtl/win_scanner.sv
// Sequential five-in-a-row judge walking H/V/D/A lines through one board read port.
// Optional: define WIN_SCANNER_DRAW_EN to compile in the full-board draw scan.
module win_scanner #(
  parameter int BOARD_DIM = 6,
  parameter int WIN_LEN   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] pos,
  input  logic [1:0] color,
  output logic [5:0] rd_addr,
  input  logic [1:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       win,
  output logic       draw,
  output logic       err
);
  import gomoku_pkg::*;

  localparam int NUM_CELLS = BOARD_DIM * BOARD_DIM;
  localparam int CNT_W     = $clog2(2 * WIN_LEN);
  localparam int STEP_W    = $clog2(WIN_LEN);

  win_state_t        state, state_n;
  logic [5:0]        pos_q, pos_n;
  logic [1:0]        color_q, color_n;
  logic [2:0]        row_q, row_n, col_q, col_n;
  logic [2:0]        split_row, split_col;
  dir_t              dir, dir_n;
  logic              side_neg, side_n;
  logic [STEP_W-1:0] step, step_n;
  logic [CNT_W-1:0]  count, count_n;
  logic [5:0]        addr_n;
  logic              win_n, err_n;
  logic              end_side;

  logic signed [1:0] dr, dc;
  logic signed [4:0] off, row_s, col_s, tr, tc;
  logic              in_bounds;
  logic [5:0]        target;

`ifdef WIN_SCANNER_DRAW_EN
  logic [5:0] draw_idx, draw_idx_n;
  logic       draw_phase, draw_phase_n;
  logic       draw_q, draw_n;
  assign draw = draw_q;
`else
  assign draw = 1'b0;
`endif

  pos_to_rc #(.BOARD_DIM(BOARD_DIM)) u_split (
    .pos (pos_q),
    .row (split_row),
    .col (split_col)
  );

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  // Probe target: origin + (step+1) * delta, with bounds checked per axis so
  // a line never wraps across a row edge.
  always_comb begin
    dr    = side_neg ? -dir_drow(dir) : dir_drow(dir);
    dc    = side_neg ? -dir_dcol(dir) : dir_dcol(dir);
    off   = signed'(5'(step)) + 5'sd1;
    row_s = signed'(5'(row_q));
    col_s = signed'(5'(col_q));
    if (dr == 2'sd1)       tr = row_s + off;
    else if (dr == -2'sd1) tr = row_s - off;
    else                   tr = row_s;
    if (dc == 2'sd1)       tc = col_s + off;
    else if (dc == -2'sd1) tc = col_s - off;
    else                   tc = col_s;
    in_bounds = (tr >= 5'sd0) && (tr < 5'(BOARD_DIM)) &&
                (tc >= 5'sd0) && (tc < 5'(BOARD_DIM));
    target = 6'(tr[2:0]) * 6'(BOARD_DIM) + 6'(tc[2:0]);
  end

  always_comb begin
    state_n  = state;
    pos_n    = pos_q;
    color_n  = color_q;
    row_n    = row_q;
    col_n    = col_q;
    dir_n    = dir;
    side_n   = side_neg;
    step_n   = step;
    count_n  = count;
    addr_n   = rd_addr;
    win_n    = win;
    err_n    = err;
    end_side = 1'b0;
`ifdef WIN_SCANNER_DRAW_EN
    draw_idx_n   = draw_idx;
    draw_phase_n = draw_phase;
    draw_n       = draw_q;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          state_n = SETUP;
          pos_n   = pos;
          color_n = color;
          win_n   = 1'b0;
          err_n   = 1'b0;
`ifdef WIN_SCANNER_DRAW_EN
          draw_n  = 1'b0;
`endif
        end
      end
      SETUP: begin
        if ({1'b0, pos_q} >= 7'(NUM_CELLS)) begin
          err_n   = 1'b1;
          state_n = DONE;
        end else begin
          row_n   = split_row;
          col_n   = split_col;
          dir_n   = H;
          side_n  = 1'b0;
          step_n  = '0;
          count_n = CNT_W'(1);
          state_n = ADV;
        end
      end
      ADV: begin
        if (in_bounds) begin
          addr_n  = target;
          state_n = PROBE;
        end else begin
          end_side = 1'b1;
        end
      end
      PROBE: state_n = CHECK;
      CHECK: begin
        if (rd_data == color_q) begin
          count_n = count + CNT_W'(1);
          step_n  = step + STEP_W'(1);
          if (count + CNT_W'(1) == CNT_W'(WIN_LEN)) begin
            win_n   = 1'b1;
            state_n = DONE;
          end else if (step + STEP_W'(1) == STEP_W'(WIN_LEN - 1)) begin
            end_side = 1'b1;
          end else begin
            state_n = ADV;
          end
        end else begin
          end_side = 1'b1;
        end
      end
`ifdef WIN_SCANNER_DRAW_EN
      // Address is issued on entry and on each advance, so each cell costs
      // one wait cycle plus one evaluate cycle.
      DRAWSCAN: begin
        if (!draw_phase) begin
          draw_phase_n = 1'b1;
        end else if (rd_data == EMPTY) begin
          state_n = DONE;
        end else if (draw_idx == 6'(NUM_CELLS - 1)) begin
          draw_n  = 1'b1;
          state_n = DONE;
        end else begin
          draw_idx_n   = draw_idx + 6'd1;
          addr_n       = draw_idx + 6'd1;
          draw_phase_n = 1'b0;
        end
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Finishing a side: + flips to -, keeping the count; - moves to the next line.
    if (end_side) begin
      step_n  = '0;
      state_n = ADV;
      if (!side_neg) begin
        side_n = 1'b1;
      end else if (dir == A) begin
`ifdef WIN_SCANNER_DRAW_EN
        state_n      = DRAWSCAN;
        addr_n       = '0;
        draw_idx_n   = '0;
        draw_phase_n = 1'b0;
`else
        state_n      = DONE;
`endif
      end else begin
        dir_n   = dir_t'(dir + 2'd1);
        side_n  = 1'b0;
        count_n = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pos_q    <= '0;
      color_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      dir      <= H;
      side_neg <= 1'b0;
      step     <= '0;
      count    <= '0;
      rd_addr  <= '0;
      win      <= 1'b0;
      err      <= 1'b0;
`ifdef WIN_SCANNER_DRAW_EN
      draw_idx   <= '0;
      draw_phase <= 1'b0;
      draw_q     <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      pos_q    <= pos_n;
      color_q  <= color_n;
      row_q    <= row_n;
      col_q    <= col_n;
      dir      <= dir_n;
      side_neg <= side_n;
      step     <= step_n;
      count    <= count_n;
      rd_addr  <= addr_n;
      win      <= win_n;
      err      <= err_n;
`ifdef WIN_SCANNER_DRAW_EN
      draw_idx   <= draw_idx_n;
      draw_phase <= draw_phase_n;
      draw_q     <= draw_n;
`endif
    end
  end

endmodule

// File: tb/tb_win_scanner.sv
// Self-checking bench for win_scanner: directed board cases plus random boards
// judged by a direct line-counting model of the board.
module tb_win_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] pos;
  logic [1:0] color;
  logic [5:0] rd_addr;
  logic [1:0] rd_data;
  logic       busy, done, win, draw, err;

  logic [1:0] board [64];

  int n_checks = 0;
  int n_fail   = 0;

  int   r_cyc, r_ndone;
  logic r_timeout, r_saw6, r_addr_bad, r_addr_moved, r_busy_rise, r_busy_at_done;
  logic r_win, r_draw, r_err;

`ifdef WIN_SCANNER_DRAW_EN
  localparam bit DRAW_EN = 1'b1;
`else
  localparam bit DRAW_EN = 1'b0;
`endif
  localparam int CYC_BOUND = DRAW_EN ? (80 + 72) : 80;

  always #5 clk = ~clk;

  // Board register file with a registered read port.
  always @(posedge clk) rd_data <= board[rd_addr];

  win_scanner #(.BOARD_DIM(6), .WIN_LEN(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pos     (pos),
    .color   (color),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .win     (win),
    .draw    (draw),
    .err     (err)
  );

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = 2'd0;
  endtask

  // Reference: walk each line outward until a foreign cell or the edge.
  function automatic void model(input int p, input int c,
                                output logic w, output logic d, output logic e);
    int drs[4] = '{0, 1, 1, 1};
    int dcs[4] = '{1, 0, 1, -1};
    int r0, c0, len, rr, cc;
    w = 1'b0;
    d = 1'b0;
    e = (p >= 36);
    if (e) return;
    r0 = p / 6;
    c0 = p % 6;
    for (int k = 0; k < 4; k++) begin
      len = 1;
      for (int s = -1; s <= 1; s += 2) begin
        rr = r0 + s * drs[k];
        cc = c0 + s * dcs[k];
        while (rr >= 0 && rr < 6 && cc >= 0 && cc < 6 && int'(board[rr*6+cc]) == c) begin
          len++;
          rr += s * drs[k];
          cc += s * dcs[k];
        end
      end
      if (len >= 5) w = 1'b1;
    end
    if (!w && DRAW_EN) begin
      d = 1'b1;
      for (int i = 0; i < 36; i++) if (board[i] == 2'd0) d = 1'b0;
    end
  endfunction

  // Issues one start and follows the scan to its done pulse (bounded).
  task automatic run_scan(input logic [5:0] p, input logic [1:0] c);
    logic [5:0] addr0;
    @(negedge clk);
    addr0 = rd_addr;
    start = 1'b1;
    pos   = p;
    color = c;
    @(negedge clk);
    start = 1'b0;
    r_busy_rise    = busy;
    r_cyc          = 1;
    r_timeout      = 1'b1;
    r_saw6         = 1'b0;
    r_addr_bad     = 1'b0;
    r_addr_moved   = 1'b0;
    r_busy_at_done = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (rd_addr == 6'd6) r_saw6 = 1'b1;
      if (rd_addr >= 6'd36) r_addr_bad = 1'b1;
      if (rd_addr != addr0) r_addr_moved = 1'b1;
      if (done === 1'b1) begin
        r_timeout      = 1'b0;
        r_busy_at_done = busy;
        break;
      end
      @(negedge clk);
      r_cyc++;
    end
    r_ndone = r_timeout ? 0 : 1;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) r_ndone++;
    end
    r_win  = win;
    r_draw = draw;
    r_err  = err;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    pos   = '0;
    color = '0;
    clear_board();
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    n_checks++; if (win !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_win: got %b want 0", win); end
    n_checks++; if (draw !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_draw: got %b want 0", draw); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b want 0", err); end
    n_checks++; if (rd_addr !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_addr: got %0d want 0", rd_addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lines();
    clear_board();
    for (int i = 0; i < 5; i++) board[i] = 2'd1;
    run_scan(6'd4, 2'd1);
    $display("[TB] row win scan took %0d cycles", r_cyc);
    n_checks++; if (r_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL row_timeout: no done within budget"); end
    n_checks++; if (r_cyc > 80) begin n_fail++; $display("[TB] FAIL row_latency: got %0d want <= 80", r_cyc); end
    n_checks++; if (r_win !== 1'b1) begin n_fail++; $display("[TB] FAIL row_win: got %b want 1", r_win); end
    n_checks++; if (r_draw !== 1'b0) begin n_fail++; $display("[TB] FAIL row_draw: got %b want 0", r_draw); end
    n_checks++; if (r_err !== 1'b0) begin n_fail++; $display("[TB] FAIL row_err: got %b want 0", r_err); end
    n_checks++; if (r_busy_rise !== 1'b1) begin n_fail++; $display("[TB] FAIL row_busy_rise: got %b want 1", r_busy_rise); end
    n_checks++; if (r_busy_at_done !== 1'b0) begin n_fail++; $display("[TB] FAIL row_busy_at_done: got %b want 0", r_busy_at_done); end
    n_checks++; if (r_ndone !== 1) begin n_fail++; $display("[TB] FAIL row_done_count: got %0d want 1", r_ndone); end

    clear_board();
    board[5] = 2'd2; board[10] = 2'd2; board[15] = 2'd2; board[20] = 2'd2; board[25] = 2'd2;
    run_scan(6'd15, 2'd2);
    n_checks++; if (r_win !== 1'b1) begin n_fail++; $display("[TB] FAIL anti_diag_win: got %b want 1", r_win); end

    clear_board();
    for (int i = 5; i < 10; i++) board[i] = 2'd1;
    run_scan(6'd5, 2'd1);
    n_checks++; if (r_win !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_win: got %b want 0", r_win); end
    n_checks++; if (r_saw6 !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_addr6: got %b want 0", r_saw6); end
  endtask

  task automatic test_full_board();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        board[r*6+c] = 2'(((c >> 1) + r) % 2 + 1);
    run_scan(6'd35, board[35]);
    n_checks++; if (r_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL full_timeout: no done within budget"); end
    n_checks++; if (r_cyc > CYC_BOUND) begin n_fail++; $display("[TB] FAIL full_latency: got %0d want <= %0d", r_cyc, CYC_BOUND); end
    n_checks++; if (r_win !== 1'b0) begin n_fail++; $display("[TB] FAIL full_win: got %b want 0", r_win); end
    n_checks++; if (r_draw !== DRAW_EN) begin n_fail++; $display("[TB] FAIL full_draw: got %b want %b", r_draw, DRAW_EN); end
    n_checks++; if (r_addr_bad !== 1'b0) begin n_fail++; $display("[TB] FAIL full_addr_range: out-of-range rd_addr seen"); end
    board[30] = 2'd0;
    run_scan(6'd35, board[35]);
    n_checks++; if (r_draw !== 1'b0) begin n_fail++; $display("[TB] FAIL hole_draw: got %b want 0", r_draw); end
    n_checks++; if (r_win !== 1'b0) begin n_fail++; $display("[TB] FAIL hole_win: got %b want 0", r_win); end
  endtask

  task automatic test_bad_pos();
    run_scan(6'd36, 2'd1);
    n_checks++; if (r_cyc !== 2) begin n_fail++; $display("[TB] FAIL bad_pos_latency: got %0d want 2", r_cyc); end
    n_checks++; if (r_err !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_pos_err: got %b want 1", r_err); end
    n_checks++; if (r_win !== 1'b0) begin n_fail++; $display("[TB] FAIL bad_pos_win: got %b want 0", r_win); end
    n_checks++; if (r_addr_moved !== 1'b0) begin n_fail++; $display("[TB] FAIL bad_pos_read: rd_addr changed, want no read"); end
  endtask

  task automatic test_back_to_back();
    int ndone;
    logic to;
    clear_board();
    board[14] = 2'd1;
    @(negedge clk);
    start = 1'b1; pos = 6'd14; color = 2'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; pos = 6'd36; color = 2'd2;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    to    = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (done === 1'b1) begin ndone++; to = 1'b0; end
      @(negedge clk);
    end
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_timeout: no done within budget"); end
    n_checks++; if (ndone !== 1) begin n_fail++; $display("[TB] FAIL b2b_done_count: got %0d want 1", ndone); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_err: got %b want 0", err); end
    run_scan(6'd36, 2'd1);
    n_checks++; if (r_err !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_next_err: got %b want 1", r_err); end
  endtask

  task automatic test_reset_mid_scan();
    int ndone;
    logic w, d, e;
    clear_board();
    board[14] = 2'd1;
    @(negedge clk);
    start = 1'b1; pos = 6'd14; color = 2'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_busy_after: got %b want 0", busy); end
    ndone = 0;
    repeat (200) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    n_checks++; if (ndone !== 0) begin n_fail++; $display("[TB] FAIL mid_aborted_done: got %0d want 0", ndone); end
    run_scan(6'd14, 2'd1);
    model(14, 1, w, d, e);
    n_checks++; if (r_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_fresh_timeout: no done within budget"); end
    n_checks++; if (r_win !== w) begin n_fail++; $display("[TB] FAIL mid_fresh_win: got %b want %b", r_win, w); end
  endtask

  task automatic test_random();
    int   p, c;
    logic w, d, e;
    bit   full;
    for (int t = 0; t < 40; t++) begin
      p    = $urandom_range(0, 39);
      c    = $urandom_range(1, 2);
      full = ($urandom_range(0, 3) == 0);
      clear_board();
      for (int i = 0; i < 36; i++) begin
        if (!full && $urandom_range(0, 9) < 2) board[i] = 2'd0;
        else board[i] = 2'($urandom_range(1, 2));
      end
      if (p < 36) board[p] = 2'(c);
      model(p, c, w, d, e);
      run_scan(6'(p), 2'(c));
      n_checks++; if (r_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL rand%0d_timeout: no done (pos %0d)", t, p); end
      n_checks++; if (r_cyc > CYC_BOUND) begin n_fail++; $display("[TB] FAIL rand%0d_latency: got %0d want <= %0d", t, r_cyc, CYC_BOUND); end
      n_checks++; if (r_win !== w) begin n_fail++; $display("[TB] FAIL rand%0d_win: got %b want %b (pos %0d)", t, r_win, w, p); end
      n_checks++; if (r_draw !== d) begin n_fail++; $display("[TB] FAIL rand%0d_draw: got %b want %b (pos %0d)", t, r_draw, d, p); end
      n_checks++; if (r_err !== e) begin n_fail++; $display("[TB] FAIL rand%0d_err: got %b want %b (pos %0d)", t, r_err, e, p); end
      n_checks++; if (r_addr_bad !== 1'b0) begin n_fail++; $display("[TB] FAIL rand%0d_addr_range: out-of-range rd_addr seen", t); end
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lines();
    test_full_board();
    test_bad_pos();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
